// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL         = 5'h04;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inslot;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for fetched data that arrives while decode is stalled.
module fetch_skid_buf
  import pc_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output logic         valid_o,
  output fetch_entry_t dout_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      entry_q <= din_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = entry_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: single-outstanding memory requests, branch/flush redirect, delay-slot tagging.
// Optional macro IF_ADEL_EN adds misaligned-PC detection with output if_adel_o.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall_i,
  input  logic        if_flush_i,
  input  logic [31:0] if_flush_pc_i,
  input  logic        branch_en_i,
  input  logic [31:0] branch_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_inslot_o,
  output logic        id_valid_o,
  output logic        if_stallreq_o
`ifdef IF_ADEL_EN
  , output logic      if_adel_o
`endif
);

  logic [31:0]  pc_q, pc_d, redir_pc_q, redir_pc_d, req_pc_q, req_pc_d;
  logic         run_q, outst_q, outst_d, drop_q, drop_d, redir_q, redir_d;
  logic         req_slot_q, req_slot_d, id_valid_q, id_valid_d;
  fetch_entry_t id_q, id_d, data_entry, skid_out, skid_tagged;
  logic         skid_valid, skid_push, skid_pop, skid_clr;
  logic         accept, take_data, br, slot_asked, adel_w;
  logic [31:0]  slot_pc;

`ifdef IF_ADEL_EN
  logic adel_q, adel_d;
  assign adel_w    = (pc_q[1:0] != 2'b00);
  assign if_adel_o = adel_q;
`else
  assign adel_w = 1'b0;
`endif

  // run_q keeps the request line low during and immediately out of reset
  assign inst_req_o  = run_q & ~outst_q & ~skid_valid & ~if_flush_i & ~adel_w;
  assign inst_addr_o = pc_q;
  assign accept      = inst_req_o & inst_addr_ok_i;
  assign take_data   = outst_q & inst_data_ok_i & ~drop_q;
  assign br          = branch_en_i & id_valid_q & ~if_stall_i & ~if_flush_i;
  assign slot_pc     = id_q.pc + 32'd4;
  assign slot_asked  = (pc_q != slot_pc);

  // A delay slot already in flight picks up its tag on the way into decode
  assign data_entry  = '{pc: req_pc_q, inst: inst_rdata_i,
                         inslot: req_slot_q | (br & (req_pc_q == slot_pc))};
  assign skid_tagged = '{pc: skid_out.pc, inst: skid_out.inst,
                         inslot: skid_out.inslot | (br & (skid_out.pc == slot_pc))};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (skid_clr),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .din_i   (data_entry),
    .valid_o (skid_valid),
    .dout_o  (skid_out)
  );

  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    req_pc_d   = req_pc_q;
    req_slot_d = req_slot_q;
    id_d       = id_q;
    id_valid_d = id_valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clr   = 1'b0;
`ifdef IF_ADEL_EN
    adel_d     = adel_q;
    if (if_flush_i | ~if_stall_i) adel_d = 1'b0;
`endif
    if (outst_q & inst_data_ok_i) begin
      outst_d = 1'b0;
      drop_d  = 1'b0;
    end
    if (if_flush_i) begin
      pc_d        = if_flush_pc_i;
      redir_d     = 1'b0;
      skid_clr    = 1'b1;
      id_valid_d  = 1'b0;
      id_d.inst   = NOP_INST;
      id_d.inslot = 1'b0;
      drop_d      = outst_q & ~inst_data_ok_i;
    end else begin
      if (accept) begin
        outst_d  = 1'b1;
        req_pc_d = pc_q;
        if (redir_q) begin
          pc_d       = redir_pc_q;
          redir_d    = 1'b0;
          req_slot_d = 1'b1;
        end else begin
          pc_d       = pc_q + 32'd4;
          req_slot_d = 1'b0;
        end
      end
      if (br) begin
        if (slot_asked) begin
          pc_d = branch_pc_i;
          if (outst_q & ~inst_data_ok_i & (req_pc_q == slot_pc)) req_slot_d = 1'b1;
        end else if (accept) begin
          pc_d       = branch_pc_i;
          req_slot_d = 1'b1;
        end else begin
          redir_d    = 1'b1;
          redir_pc_d = branch_pc_i;
        end
      end
      if (!if_stall_i) begin
        if (skid_valid) begin
          id_d       = skid_tagged;
          id_valid_d = 1'b1;
          skid_pop   = 1'b1;
        end else if (take_data) begin
          id_d       = data_entry;
          id_valid_d = 1'b1;
`ifdef IF_ADEL_EN
        end else if (adel_w & ~outst_q) begin
          id_d       = '{pc: pc_q, inst: NOP_INST, inslot: 1'b0};
          id_valid_d = 1'b1;
          adel_d     = 1'b1;
`endif
        end else begin
          id_valid_d  = 1'b0;
          id_d.inst   = NOP_INST;
          id_d.inslot = 1'b0;
        end
      end else if (take_data) begin
        skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      req_pc_q   <= '0;
      req_slot_q <= 1'b0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      req_pc_q   <= req_pc_d;
      req_slot_q <= req_slot_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IF_ADEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adel_q <= 1'b0;
    else        adel_q <= adel_d;
  end
`endif

  assign id_pc_o       = id_q.pc;
  assign id_inst_o     = id_q.inst;
  assign id_inslot_o   = id_q.inslot;
  assign id_valid_o    = id_valid_q;
  assign if_stallreq_o = ~id_valid_q & ~if_flush_i;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: memory responder plus program-order model of what decode must see.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0, aok = 1'b0, dok = 1'b0;
  logic [31:0] flush_pc = '0, br_pc = '0, rdata = '0;
  logic        inst_req_o, id_inslot_o, id_valid_o, if_stallreq_o;
  logic [31:0] inst_addr_o, id_pc_o, id_inst_o;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .if_stall_i(stall), .if_flush_i(flush),
    .if_flush_pc_i(flush_pc), .branch_en_i(br), .branch_pc_i(br_pc),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(aok), .inst_data_ok_i(dok), .inst_rdata_i(rdata),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_inslot_o(id_inslot_o),
    .id_valid_o(id_valid_o), .if_stallreq_o(if_stallreq_o)
  );

  int checks = 0, errors = 0;
  // program-order model: next PC decode must receive, its slot tag, pending branch target
  logic [31:0] exp_pc;
  logic        exp_slot, pend;
  logic [31:0] pend_tgt;
  // memory responder
  logic        mem_busy;
  int          mem_cnt, mem_delay;
  logic [31:0] mem_addr;
  // stimulus modes
  logic        ideal, block_aok, auto_br, force_flush;
  logic [31:0] auto_br_pc, auto_br_tgt, force_flush_pc;
  logic        prev_pend_req;
  logic [31:0] prev_addr;
  int          idle;
  logic [31:0] acc_q[$];
  logic [31:0] del_pc_q[$];
  logic        del_slot_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_pc();
    return 32'hBFC0_0000 + (32'($urandom_range(0, 1023)) << 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    exp_pc = RPC; exp_slot = 1'b0; pend = 1'b0; pend_tgt = '0;
    mem_busy = 1'b0; mem_cnt = 0; prev_pend_req = 1'b0; idle = 0;
  endtask

  task automatic clear_logs();
    acc_q.delete(); del_pc_q.delete(); del_slot_q.delete();
  endtask

  task automatic step();
    int d;
    logic [31:0] cur;
    @(posedge clk); #1;
    aok   = block_aok ? 1'b0 : (ideal ? 1'b1 : ($urandom_range(0, 3) != 0));
    dok   = mem_busy && (mem_cnt == 0);
    rdata = dok ? memf(mem_addr) : $urandom;
    stall = ideal ? 1'b0 : ($urandom_range(0, 4) == 0);
    flush = force_flush | (!ideal && ($urandom_range(0, 39) == 0));
    flush_pc = force_flush ? force_flush_pc : rand_pc();
    br = id_valid_o && !stall && !flush && !id_inslot_o && !pend &&
         (auto_br ? (id_pc_o == auto_br_pc) : (!ideal && ($urandom_range(0, 3) == 0)));
    br_pc = auto_br ? auto_br_tgt : rand_pc();
    #4;
    chk("stallreq", {31'b0, if_stallreq_o}, {31'b0, ~id_valid_o & ~flush});
    if (!id_valid_o) chk("nop_when_invalid", id_inst_o, NOP_INST);
    if (prev_pend_req && !flush) begin
      chk("req_held", {31'b0, inst_req_o}, 32'd1);
      chk("addr_stable", inst_addr_o, prev_addr);
    end
    chk("single_outstanding", {31'b0, inst_req_o & mem_busy}, 32'd0);
    if (dok) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (inst_req_o && aok) begin
      d = ideal ? mem_delay : int'($urandom_range(1, 3));
      acc_q.push_back(inst_addr_o);
      mem_busy = 1'b1; mem_addr = inst_addr_o; mem_cnt = d - 1;
    end
    prev_pend_req = inst_req_o & ~aok;
    prev_addr     = inst_addr_o;
    if (id_valid_o && !stall && !flush) begin
      cur = exp_pc;
      chk("deliver_pc", id_pc_o, cur);
      chk("deliver_inst", id_inst_o, memf(cur));
      chk("deliver_inslot", {31'b0, id_inslot_o}, {31'b0, exp_slot});
      del_pc_q.push_back(id_pc_o);
      del_slot_q.push_back(id_inslot_o);
      if (br) begin
        exp_pc = cur + 32'd4; exp_slot = 1'b1; pend = 1'b1; pend_tgt = br_pc;
      end else if (pend) begin
        exp_pc = pend_tgt; exp_slot = 1'b0; pend = 1'b0;
      end else begin
        exp_pc = cur + 32'd4; exp_slot = 1'b0;
      end
    end
    if (flush) begin
      exp_pc = flush_pc; exp_slot = 1'b0; pend = 1'b0;
    end
    idle = (id_valid_o || flush) ? 0 : idle + 1;
    if (idle > 60) begin
      chk("liveness_idle_cycles", 32'(idle), 32'd60);
      idle = 0;
    end
  endtask

  task automatic chk_q(input string name, input int idx, input logic [31:0] expv, input bit from_acc);
    if (from_acc) begin
      if (acc_q.size() > idx) chk(name, acc_q[idx], expv);
      else chk({name, "_missing"}, 32'(acc_q.size()), 32'(idx + 1));
    end else begin
      if (del_pc_q.size() > idx) chk(name, del_pc_q[idx], expv);
      else chk({name, "_missing"}, 32'(del_pc_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    ideal = 1'b1; block_aok = 1'b0; auto_br = 1'b0; force_flush = 1'b0;
    auto_br_pc = '0; auto_br_tgt = '0; force_flush_pc = '0; mem_delay = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, inst_req_o}, 32'd0);
    chk("rst_addr", inst_addr_o, RPC);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_id_pc", id_pc_o, 32'd0);
    chk("rst_id_inst", id_inst_o, 32'd0);
    chk("rst_inslot", {31'b0, id_inslot_o}, 32'd0);
    chk("rst_stallreq", {31'b0, if_stallreq_o}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // sequential fetch from the reset vector
    clear_logs();
    repeat (10) step();
    chk_q("seq_acc0", 0, 32'hBFC0_0000, 1'b1);
    chk_q("seq_acc1", 1, 32'hBFC0_0004, 1'b1);
    chk_q("seq_acc2", 2, 32'hBFC0_0008, 1'b1);
    chk_q("seq_del0", 0, 32'hBFC0_0000, 1'b0);

    // branch at 0x100 to 0x200 whose delay slot is not yet requested
    force_flush = 1'b1; force_flush_pc = 32'h0000_0100;
    step();
    force_flush = 1'b0; clear_logs();
    auto_br = 1'b1; auto_br_pc = 32'h0000_0100; auto_br_tgt = 32'h0000_0200;
    repeat (14) step();
    auto_br = 1'b0;
    chk_q("br_acc0", 0, 32'h0000_0100, 1'b1);
    chk_q("br_acc1", 1, 32'h0000_0104, 1'b1);
    chk_q("br_acc2", 2, 32'h0000_0200, 1'b1);
    chk_q("br_del0", 0, 32'h0000_0100, 1'b0);
    chk_q("br_del1", 1, 32'h0000_0104, 1'b0);
    chk_q("br_del2", 2, 32'h0000_0200, 1'b0);
    if (del_slot_q.size() > 1) chk("br_slot_tag", {31'b0, del_slot_q[1]}, 32'd1);
    else chk("br_slot_tag_missing", 32'(del_slot_q.size()), 32'd2);

    // flush while a slow request is outstanding: its data must be dropped
    mem_delay = 3;
    for (int i = 0; i < 10 && !mem_busy; i++) step();
    chk("flush_setup_busy", {31'b0, mem_busy}, 32'd1);
    clear_logs();
    force_flush = 1'b1; force_flush_pc = 32'hBFC0_0380;
    step();
    force_flush = 1'b0; mem_delay = 1;
    repeat (12) step();
    chk_q("flush_acc0", 0, 32'hBFC0_0380, 1'b1);
    chk_q("flush_del0", 0, 32'hBFC0_0380, 1'b0);

    // address phase refused for several cycles
    block_aok = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("blk_req", {31'b0, inst_req_o}, 32'd1);
      chk("blk_stallreq", {31'b0, if_stallreq_o}, 32'd1);
    end
    block_aok = 1'b0;

    // randomized traffic
    ideal = 1'b0;
    repeat (3000) step();

    // reset in the middle of an outstanding request
    ideal = 1'b1; mem_delay = 3;
    for (int i = 0; i < 20 && !mem_busy; i++) step();
    @(posedge clk); #2 rst_n = 1'b0;
    flush = 1'b0; br = 1'b0; dok = 1'b0; stall = 1'b0;
    #2;
    chk("midrst_req", {31'b0, inst_req_o}, 32'd0);
    chk("midrst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("midrst_addr", inst_addr_o, RPC);
    model_reset(); clear_logs(); mem_delay = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) step();
    chk_q("midrst_acc0", 0, RPC, 1'b1);
    chk_q("midrst_del0", 0, RPC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_stall_i  in  1  controller stall; holds all ID-facing outputs.
REQ-006 if_flush_i  in  1  controller flush (exception or eret redirect).
REQ-007 if_flush_pc_i  in  32  redirect address accompanying if_flush_i.
REQ-008 branch_en_i  in  1  taken branch from the decode stage, valid when decode is not stalled.
REQ-009 branch_pc_i  in  32  branch target.
REQ-010 inst_req_o  out  1  instruction-memory request.
REQ-011 inst_addr_o  out  32  request address.
REQ-012 inst_addr_ok_i  in  1  request accepted this cycle.
REQ-013 inst_data_ok_i  in  1  read data valid this cycle.
REQ-014 inst_rdata_i  in  32  read data.
REQ-015 id_pc_o  out  32  registered PC to decode.
REQ-016 id_inst_o  out  32  registered instruction to decode; 32'h0 (nop) when not valid.
REQ-017 id_inslot_o  out  1  instruction is a branch delay slot.
REQ-018 id_valid_o  out  1  id_* outputs carry a real instruction.
REQ-019 if_stallreq_o  out  1  fetch cannot supply decode this cycle (no valid instruction ready).

Function
REQ-020 pc_reg holds the next address to request; inst_addr_o = pc_reg.
REQ-021 inst_req_o is high only when there is no outstanding request, the skid buffer is empty, and if_flush_i is low; it is held until inst_addr_ok_i.
REQ-022 At most one request is outstanding; on req & addr_ok, outstanding is set and pc_reg advances to pc_reg+4, or to the redirect target if a redirect is pending and the accepted address is the delay slot.
REQ-023 On inst_data_ok_i, outstanding clears; with if_stall_i low the data loads id_* on the same edge (latency 1 cycle after data_ok); with if_stall_i high it loads a 1-entry skid buffer.
REQ-024 With if_stall_i low and the skid buffer full, the buffer drains into id_*; otherwise id_valid_o becomes 0 and id_inst_o 32'h0.
REQ-025 If branch_en_i is high and the delay slot (id_pc_o+4) has already been requested (pc_reg != id_pc_o+4), pc_reg loads branch_pc_i directly.
REQ-026 Otherwise branch_en_i sets redirect_pending with the target latched; the redirect applies when the delay-slot request is accepted.
REQ-027 The instruction at id_pc_o+4 following a taken branch is tagged inslot and delivered with id_inslot_o=1.
REQ-028 if_flush_i has priority over branch and stall: pc_reg <= if_flush_pc_i, redirect_pending cleared, skid buffer cleared, id_valid_o <= 0, and a drop flag is set if a request is outstanding.
REQ-029 When the drop flag is set, the next inst_data_ok_i is discarded and the flag is cleared.
REQ-030 if_stallreq_o = ~id_valid_o & ~if_flush_i.

Reset
REQ-031 On rst_n low: pc_reg = RESET_PC, outstanding/drop/redirect_pending/buffer-valid = 0, id_pc_o = 0, id_inst_o = 0, id_inslot_o = 0, id_valid_o = 0, inst_req_o = 0.
REQ-032 Reset asserted mid-transaction abandons the transaction; the first request after deassertion is RESET_PC.

Configuration
REQ-033 Macro IF_ADEL_EN: when defined, a misaligned pc_reg (bits [1:0] != 0) issues no request and delivers id_valid_o=1, id_inst_o=0, plus an extra output if_adel_o=1; when undefined, if_adel_o is absent and pc[1:0] is ignored.

Structure
REQ-034 RESET_PC default, the nop encoding and the IF_ADEL_EN exception code constant live in the shared defines package.
REQ-035 The skid buffer is one sub-module, fetch_skid_buf (1-entry, pc/inst/inslot).

Verification
REQ-036 Reset, addr_ok=1, data_ok one cycle later -> requests BFC0_0000, _0004, _0008 in sequence; id_valid_o rises with id_pc_o = BFC0_0000.
REQ-037 Branch at 0x100 in decode, delay slot not yet requested, target 0x200 -> next addresses 0x104 then 0x200; 0x104 delivered with id_inslot_o=1.
REQ-038 if_stall_i held 3 cycles while data_ok arrives -> id_* frozen, no new request, buffered instruction delivered on the first unstalled edge.
REQ-039 if_flush_i with if_flush_pc_i = BFC0_0380 while a request is outstanding -> late data_ok dropped; next request BFC0_0380; id_valid_o = 0 until its data arrives.
REQ-040 addr_ok held low 5 cycles -> inst_req_o and inst_addr_o stable; if_stallreq_o = 1 throughout.
